regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Writeback arbiter between the execution units and the register file's single synchronous write port. It accepts results from two producers over valid/ready handshakes: the single-cycle ALU and the long-latency load/store unit (LSU). Each producer has its own small FIFO, and the arbiter drains them round-robin into a registered write port (rf_we/rf_waddr/rf_wdata). It also exports a pending-destination bitmap that decode uses for RAW/WAW stalls. Writes to x0 are dropped at the input.

## Interface
- WIDTH, 32, data width; must match the register file.
- DEPTH, 32, number of architectural registers; AW = $clog2(DEPTH).
- QDEPTH, 2, entries per producer FIFO; power of two, ≥2.

- clk  input  1  sole clock; all state updates on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- alu_valid  input  1  ALU result valid.
- alu_ready  output  1  ALU FIFO can accept.
- alu_rd  input  AW  ALU destination register.
- alu_data  input  WIDTH  ALU result.
- lsu_valid  input  1  LSU result valid.
- lsu_ready  output  1  LSU FIFO can accept.
- lsu_rd  input  AW  LSU destination register.
- lsu_data  input  WIDTH  LSU result.
- rf_we  output  1  register-file write enable (registered).
- rf_waddr  output  AW  register-file write address (registered).
- rf_wdata  output  WIDTH  register-file write data (registered).
- busy_mask  output  DEPTH  bit r=1 while a write to r is pending inside this block.

## Operation
- **Handshake:**
  - A transfer occurs on a posedge with x_valid && x_ready.
  - x_ready = !fifo_x_full && rst_n. It depends only on registered state and has no combinational path from x_valid.
  - x_rd/x_data are sampled only on a transfer. x_valid may drop without a transfer.
- **x0 filtering:** an accepted item with rd==0 is consumed and not enqueued. It produces no rf_we and no busy_mask bit.
- **FIFOs:**
  - Each FIFO holds QDEPTH entries {rd, data}, with pointers that wrap modulo QDEPTH and a count of width $clog2(QDEPTH)+1.
  - A full FIFO accepts nothing.
  - Enqueue and dequeue on the same edge are legal whenever the FIFO is not full. Count is unchanged and both pointers advance.
- **Arbitration (once per cycle, combinational on FIFO heads):**
  - Both FIFOs empty: no grant. rf_we goes to 0 at the next edge.
  - One FIFO non-empty: grant it.
  - Both non-empty: grant the source not recorded in last_grant.
  - On each grant, last_grant is set to the granted source and the granted head is dequeued.
- **Output register:** on a grant edge, {rf_we, rf_waddr, rf_wdata} <= {1, head.rd, head.data}. Otherwise rf_we <= 0, and rf_waddr/rf_wdata hold their previous values.
- **busy_mask:** OR over every valid entry of both FIFOs plus the output register when rf_we=1, each contributing (1<<rd). It is combinational from registered state only.
- **Same-rd ordering:** no ordering is guaranteed between sources. Decode must stall issue to any rd whose busy_mask bit is set. Within one source, FIFO order is preserved.

## Timing
- **Reset (rst_n low, async):**
  - Both FIFOs empty, pointers 0.
  - last_grant=LSU, so the ALU wins the first tie.
  - rf_we=0, rf_waddr=0, rf_wdata=0, busy_mask=0.
  - alu_ready=lsu_ready=0 while rst_n is low; they go to 1 in the first cycle after deassertion.
- **Reset mid-operation:** all queued results are discarded. Nothing further is written.
- **Latency, item accepted at edge N into an empty block with no competition:**
  - busy_mask bit set during cycle N→N+1.
  - rf_we=1 during cycle N+1→N+2 (granted at edge N+1).
  - Register file commits at edge N+2.
  - busy_mask bit clears after edge N+2, unless another pending write targets the same rd.
- **Throughput:** one register-file write per cycle aggregate. Each source sustains one item/cycle when uncontended. Under contention, each source gets one grant every 2 cycles.
- **Backpressure:** x_ready falls in the cycle after the edge that fills the FIFO. It rises in the cycle after the edge that dequeues from it.

## Test plan
- **Reset values:** assert rst_n=0 mid-stream with both FIFOs holding items → outputs immediately rf_we=0, busy_mask=0, readys=0. After release, no stale write ever appears.
- **Single ALU item:** ALU sends rd=5, data=0xDEADBEEF at edge N → busy_mask[5]=1 during N→N+2. rf_we=1, waddr=5, wdata=0xDEADBEEF during N+1→N+2. The register file reads back 0xDEADBEEF afterwards.
- **x0 drop:** LSU sends rd=0, data=0x1234 → accepted (lsu_ready=1), rf_we stays 0, busy_mask stays 0.
- **Tie round-robin:** both FIFOs pre-filled with 2 items each (ALU rd 1,2; LSU rd 3,4), no further input → rf_waddr sequence 1,3,2,4 on 4 consecutive cycles, then rf_we=0.
- **Full/backpressure:** QDEPTH=2, LSU streams every cycle while ALU also streams → lsu_ready drops after the FIFO fills. No item is lost or duplicated: every accepted (rd,data) appears exactly once on rf_*, in per-source order.
- **Wrap-around:** 10 ALU items back-to-back with no LSU traffic → 10 consecutive rf_we cycles carrying rd 1..10 in order; pointers wrap without a bubble.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter between the execution units and the register file's single write port.
// It queues results from the ALU and the LSU in two small FIFOs and drains them round-robin
// into a registered write port.
// Ports:
//   clk, rst_n                       clock and asynchronous active-low reset
//   alu_valid/alu_ready/alu_rd/data  ALU result handshake (ready has no path from valid)
//   lsu_valid/lsu_ready/lsu_rd/data  LSU result handshake
//   rf_we/rf_waddr/rf_wdata          registered register-file write port
//   busy_mask                        destinations with a write still pending in this block
module regfile_wb_arbiter #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned QDEPTH = 2,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alu_valid,
  output logic             alu_ready,
  input  logic [AW-1:0]    alu_rd,
  input  logic [WIDTH-1:0] alu_data,
  input  logic             lsu_valid,
  output logic             lsu_ready,
  input  logic [AW-1:0]    lsu_rd,
  input  logic [WIDTH-1:0] lsu_data,
  output logic             rf_we,
  output logic [AW-1:0]    rf_waddr,
  output logic [WIDTH-1:0] rf_wdata,
  output logic [DEPTH-1:0] busy_mask
);

  localparam int unsigned PW   = $clog2(QDEPTH);
  localparam int unsigned CW   = $clog2(QDEPTH) + 1;
  localparam int unsigned NSRC = 2;
  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_LSU = 1'b1;

  // FIFO storage and pointers, indexed [source][slot]
  logic [AW-1:0]    rd_q   [NSRC][QDEPTH];
  logic [AW-1:0]    rd_d   [NSRC][QDEPTH];
  logic [WIDTH-1:0] data_q [NSRC][QDEPTH];
  logic [WIDTH-1:0] data_d [NSRC][QDEPTH];
  logic [PW-1:0]    wptr_q [NSRC];
  logic [PW-1:0]    wptr_d [NSRC];
  logic [PW-1:0]    rptr_q [NSRC];
  logic [PW-1:0]    rptr_d [NSRC];
  logic [CW-1:0]    cnt_q  [NSRC];
  logic [CW-1:0]    cnt_d  [NSRC];

  logic             last_grant_q, last_grant_d;
  logic             rf_we_q, rf_we_d;
  logic [AW-1:0]    rf_waddr_q, rf_waddr_d;
  logic [WIDTH-1:0] rf_wdata_q, rf_wdata_d;

  logic [NSRC-1:0]  in_valid_c;
  logic [AW-1:0]    in_rd_c   [NSRC];
  logic [WIDTH-1:0] in_data_c [NSRC];
  logic [NSRC-1:0]  full_c;
  logic [NSRC-1:0]  nonempty_c;
  logic [NSRC-1:0]  enq_c;
  logic [NSRC-1:0]  deq_c;
  logic             gnt_vld_c;
  logic             gnt_src_c;
  logic [DEPTH-1:0] busy_c;
  logic [PW-1:0]    slot_c;

  // Gather both producers into source-indexed form; x0 results are accepted but never enqueued
  always_comb begin
    in_valid_c   = {lsu_valid, alu_valid};
    in_rd_c[0]   = alu_rd;
    in_rd_c[1]   = lsu_rd;
    in_data_c[0] = alu_data;
    in_data_c[1] = lsu_data;
    for (int s = 0; s < int'(NSRC); s++) begin
      full_c[s]     = (cnt_q[s] == CW'(QDEPTH));
      nonempty_c[s] = (cnt_q[s] != '0);
      enq_c[s]      = in_valid_c[s] && !full_c[s] && (in_rd_c[s] != '0);
    end
  end

  assign alu_ready = rst_n && !full_c[0];
  assign lsu_ready = rst_n && !full_c[1];

  // Round-robin: on a tie the source that did not win last time is granted
  always_comb begin
    gnt_vld_c = |nonempty_c;
    gnt_src_c = SRC_ALU;
    if (&nonempty_c) begin
      gnt_src_c = ~last_grant_q;
    end else if (nonempty_c[SRC_LSU]) begin
      gnt_src_c = SRC_LSU;
    end
    deq_c = '0;
    if (gnt_vld_c) begin
      deq_c[gnt_src_c] = 1'b1;
    end
  end

  // Next-state: FIFO updates, grant bookkeeping and the write-port register
  always_comb begin
    rd_d         = rd_q;
    data_d       = data_q;
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    rf_we_d      = 1'b0;
    rf_waddr_d   = rf_waddr_q;
    rf_wdata_d   = rf_wdata_q;
    for (int s = 0; s < int'(NSRC); s++) begin
      if (enq_c[s]) begin
        rd_d[s][wptr_q[s]]   = in_rd_c[s];
        data_d[s][wptr_q[s]] = in_data_c[s];
        wptr_d[s]            = wptr_q[s] + PW'(1);
      end
      if (deq_c[s]) begin
        rptr_d[s] = rptr_q[s] + PW'(1);
      end
      case ({enq_c[s], deq_c[s]})
        2'b10:   cnt_d[s] = cnt_q[s] + CW'(1);
        2'b01:   cnt_d[s] = cnt_q[s] - CW'(1);
        default: cnt_d[s] = cnt_q[s];
      endcase
    end
    if (gnt_vld_c) begin
      last_grant_d = gnt_src_c;
      rf_we_d      = 1'b1;
      rf_waddr_d   = rd_q[gnt_src_c][rptr_q[gnt_src_c]];
      rf_wdata_d   = data_q[gnt_src_c][rptr_q[gnt_src_c]];
    end
  end

  // State register; last_grant resets to LSU so the ALU wins the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < int'(NSRC); s++) begin
        for (int k = 0; k < int'(QDEPTH); k++) begin
          rd_q[s][k]   <= '0;
          data_q[s][k] <= '0;
        end
        wptr_q[s] <= '0;
        rptr_q[s] <= '0;
        cnt_q[s]  <= '0;
      end
      last_grant_q <= SRC_LSU;
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
    end else begin
      rd_q         <= rd_d;
      data_q       <= data_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      rf_we_q      <= rf_we_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
    end
  end

  // Pending destinations: live FIFO slots (counted from the read pointer) plus the write port
  always_comb begin
    busy_c = '0;
    slot_c = '0;
    for (int s = 0; s < int'(NSRC); s++) begin
      for (int k = 0; k < int'(QDEPTH); k++) begin
        slot_c = rptr_q[s] + PW'(k);
        if (CW'(k) < cnt_q[s]) begin
          busy_c[rd_q[s][slot_c]] = 1'b1;
        end
      end
    end
    if (rf_we_q) begin
      busy_c[rf_waddr_q] = 1'b1;
    end
  end

  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign busy_mask = busy_c;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: per-source scoreboards filled on accepted
// transfers and drained against rf_* writes, plus a pending-count model for busy_mask.
module tb_regfile_wb_arbiter;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned AW    = 5;

  typedef struct packed {
    logic [AW-1:0]    rd;
    logic [WIDTH-1:0] data;
  } item_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             alu_valid, alu_ready, lsu_valid, lsu_ready;
  logic [AW-1:0]    alu_rd, lsu_rd;
  logic [WIDTH-1:0] alu_data, lsu_data;
  logic             rf_we;
  logic [AW-1:0]    rf_waddr;
  logic [WIDTH-1:0] rf_wdata;
  logic [DEPTH-1:0] busy_mask;

  regfile_wb_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .QDEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .busy_mask(busy_mask)
  );

  always #5 clk = ~clk;

  int               n_checks = 0;
  int               n_errors = 0;
  int               cyc = 0;
  item_t            sb_alu[$];
  item_t            sb_lsu[$];
  int unsigned      pend [DEPTH];
  logic [WIDTH-1:0] rf_model [DEPTH];
  int               wlog_addr[$];
  int               wlog_cyc[$];
  bit               lsu_stall_seen = 1'b0;
  logic [DEPTH-1:0] exp_busy;
  item_t            got_item, exp_item;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Negedge monitor: check this cycle's outputs, then record what the next posedge will do
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      sb_alu.delete();
      sb_lsu.delete();
      for (int r = 0; r < int'(DEPTH); r++) pend[r] = 0;
    end else begin
      exp_busy = '0;
      for (int r = 0; r < int'(DEPTH); r++) if (pend[r] != 0) exp_busy[r] = 1'b1;
      check("busy_mask", 64'(busy_mask), 64'(exp_busy));
      if (rf_we) begin
        got_item = '{rd: rf_waddr, data: rf_wdata};
        wlog_addr.push_back(int'(rf_waddr));
        wlog_cyc.push_back(cyc);
        if (sb_alu.size() != 0 && sb_alu[0] == got_item) exp_item = sb_alu.pop_front();
        else if (sb_lsu.size() != 0 && sb_lsu[0] == got_item) exp_item = sb_lsu.pop_front();
        else if (sb_alu.size() != 0) exp_item = sb_alu[0];
        else if (sb_lsu.size() != 0) exp_item = sb_lsu[0];
        else exp_item = ~got_item;
        check("wb_item", 64'(got_item), 64'(exp_item));
        if (pend[rf_waddr] != 0) pend[rf_waddr]--;
        rf_model[rf_waddr] = rf_wdata;
      end
      if (alu_valid && alu_ready && alu_rd != '0) begin
        sb_alu.push_back('{rd: alu_rd, data: alu_data});
        pend[alu_rd]++;
      end
      if (lsu_valid && lsu_ready && lsu_rd != '0) begin
        sb_lsu.push_back('{rd: lsu_rd, data: lsu_data});
        pend[lsu_rd]++;
      end
      if (lsu_valid && !lsu_ready) lsu_stall_seen = 1'b1;
    end
  end

  // Called at posedge+1; returns at posedge+1 of the accepting edge
  task automatic send(input bit src, input logic [AW-1:0] rd, input logic [WIDTH-1:0] data);
    bit acc;
    acc = 1'b0;
    if (!src) begin alu_valid = 1'b1; alu_rd = rd; alu_data = data; end
    else      begin lsu_valid = 1'b1; lsu_rd = rd; lsu_data = data; end
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      acc = src ? lsu_ready : alu_ready;
      @(posedge clk);
    end
    #1;
    if (!src) alu_valid = 1'b0; else lsu_valid = 1'b0;
    if (!acc) check("send_accept", 64'(acc), 64'(1));
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic check_wlog(input string tag, input int exp_addr[$]);
    check({tag, "_count"}, 64'(wlog_addr.size()), 64'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size() && i < wlog_addr.size(); i++) begin
      check({tag, "_addr"}, 64'(wlog_addr[i]), 64'(exp_addr[i]));
      check({tag, "_back2back"}, 64'(wlog_cyc[i]), 64'(wlog_cyc[0] + i));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_cnt;
    int exp_seq[$];
    for (int r = 0; r < int'(DEPTH); r++) rf_model[r] = '0;
    rst_n = 1'b0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_rf_we", 64'(rf_we), 64'(0));
    check("rst_rf_waddr", 64'(rf_waddr), 64'(0));
    check("rst_rf_wdata", 64'(rf_wdata), 64'(0));
    check("rst_busy", 64'(busy_mask), 64'(0));
    check("rst_alu_ready", 64'(alu_ready), 64'(0));
    check("rst_lsu_ready", 64'(lsu_ready), 64'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_alu_ready", 64'(alu_ready), 64'(1));
    check("post_rst_lsu_ready", 64'(lsu_ready), 64'(1));
    @(posedge clk); #1;

    // Single ALU item: latency and busy window
    send(1'b0, 5'd5, 32'hDEADBEEF);
    @(negedge clk);
    check("single_busy_n0", 64'(busy_mask[5]), 64'(1));
    check("single_we_n0", 64'(rf_we), 64'(0));
    @(negedge clk);
    check("single_we_n1", 64'(rf_we), 64'(1));
    check("single_waddr", 64'(rf_waddr), 64'(5));
    check("single_wdata", 64'(rf_wdata), 64'(32'hDEADBEEF));
    check("single_busy_n1", 64'(busy_mask[5]), 64'(1));
    @(negedge clk);
    check("single_we_n2", 64'(rf_we), 64'(0));
    check("single_busy_n2", 64'(busy_mask[5]), 64'(0));
    @(negedge clk);
    check("single_rf_readback", 64'(rf_model[5]), 64'(32'hDEADBEEF));
    @(posedge clk); #1;

    // x0 drop
    send(1'b1, 5'd0, 32'h1234);
    n_cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (rf_we || busy_mask != '0) n_cnt++;
    end
    check("x0_no_effect", 64'(n_cnt), 64'(0));
    @(posedge clk); #1;

    // Tie round-robin from a fresh reset
    do_reset();
    wlog_addr.delete(); wlog_cyc.delete();
    fork
      begin send(1'b0, 5'd1, 32'h0000_0A01); send(1'b0, 5'd2, 32'h0000_0A02); end
      begin send(1'b1, 5'd3, 32'h0000_0B03); send(1'b1, 5'd4, 32'h0000_0B04); end
    join
    repeat (6) @(negedge clk);
    exp_seq = '{1, 3, 2, 4};
    check_wlog("tie", exp_seq);
    @(posedge clk); #1;

    // Wrap-around: 10 back-to-back ALU items
    wlog_addr.delete(); wlog_cyc.delete();
    for (int i = 1; i <= 10; i++) send(1'b0, AW'(i), 32'hA000 + 32'(i));
    repeat (4) @(negedge clk);
    exp_seq = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
    check_wlog("wrap", exp_seq);
    @(posedge clk); #1;

    // Full/backpressure: both sources stream concurrently
    wlog_addr.delete(); wlog_cyc.delete();
    lsu_stall_seen = 1'b0;
    fork
      for (int i = 0; i < 8; i++) send(1'b1, AW'(16 + i), 32'hB000 + 32'(i));
      for (int i = 0; i < 8; i++) send(1'b0, AW'(8 + i), 32'hC000 + 32'(i));
    join
    repeat (8) @(negedge clk);
    check("bp_lsu_stalled", 64'(lsu_stall_seen), 64'(1));
    check("bp_write_count", 64'(wlog_addr.size()), 64'(16));
    check("bp_alu_drained", 64'(sb_alu.size()), 64'(0));
    check("bp_lsu_drained", 64'(sb_lsu.size()), 64'(0));
    @(posedge clk); #1;

    // Reset mid-stream with both FIFOs holding items
    alu_valid = 1'b1; alu_rd = 5'd9;  alu_data = 32'hE000;
    lsu_valid = 1'b1; lsu_rd = 5'd10; lsu_data = 32'hF000;
    repeat (3) begin
      @(posedge clk); #1;
      alu_data = alu_data + 32'd1;
      lsu_data = lsu_data + 32'd1;
    end
    rst_n = 1'b0;
    alu_valid = 1'b0; lsu_valid = 1'b0;
    #1;
    check("mid_rst_rf_we", 64'(rf_we), 64'(0));
    check("mid_rst_busy", 64'(busy_mask), 64'(0));
    check("mid_rst_alu_ready", 64'(alu_ready), 64'(0));
    check("mid_rst_lsu_ready", 64'(lsu_ready), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    n_cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (rf_we) n_cnt++;
    end
    check("mid_rst_no_stale_write", 64'(n_cnt), 64'(0));
    check("final_alu_sb_empty", 64'(sb_alu.size()), 64'(0));
    check("final_lsu_sb_empty", 64'(sb_lsu.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
